// File: rtl/jtframe_rstseq_pkg.sv
// Shared types and constants for the PLL-lock reset sequencer.
package jtframe_rstseq_pkg;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StFilter   = 3'd1,
    StSdram    = 3'd2,
    StVideo    = 3'd3,
    StRun      = 3'd4
  } seq_st_e;

  // Length of the PLL reset pulse raised by the watchdog
  localparam int unsigned AREST_LEN = 8;

  // Width of the shared sequencer counter: enough for the largest terminal value
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/jtframe_rstseq_sync.sv
// N-stage single-bit synchronizer with synchronous reset to 0.
module jtframe_rstseq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], din};
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/jtframe_rstseq.sv
// PLL-lock-driven reset sequencer: filters lock, then releases SDRAM, video
// and game resets in a staggered order; restarts whenever lock is lost.
// Optional PLL watchdog enabled by defining JTFRAME_PLL_WDOG_EN.
module jtframe_rstseq
  import jtframe_rstseq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILT   = 16,
  parameter int unsigned SDRAM_DLY   = 1024,
  parameter int unsigned GAME_DLY    = 256,
  parameter int unsigned WDOG_CYC    = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       rst_sdram,
  output logic       rst_video,
  output logic       rst_game,
  output logic       pll_areset,
  output logic [2:0] seq_st,
  output logic [7:0] loss_cnt
);

  localparam int unsigned CW = cnt_width(LOCK_FILT, SDRAM_DLY, GAME_DLY, WDOG_CYC);
  localparam logic [CW-1:0] FILT_END  = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] SDRAM_END = CW'(SDRAM_DLY - 1);
  localparam logic [CW-1:0] GAME_END  = CW'(GAME_DLY - 1);

  logic          lock_s;
  seq_st_e       st;
  logic [CW-1:0] cnt;

  jtframe_rstseq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pll_locked),
    .dout (lock_s)
  );

  assign seq_st = st;

  // Sequencer FSM; reset outputs are decoded from the state held before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= StWaitLock;
      cnt       <= '0;
      rst_sdram <= 1'b1;
      rst_video <= 1'b1;
      rst_game  <= 1'b1;
      loss_cnt  <= 8'd0;
    end else begin
      rst_sdram <= !(st == StSdram || st == StVideo || st == StRun);
      rst_video <= !(st == StVideo || st == StRun);
      rst_game  <= !(st == StRun);
      case (st)
        StWaitLock: begin
          if (lock_s) begin
            st  <= StFilter;
            cnt <= '0;
          end
        end
        StFilter: begin
          // A glitch while filtering is not counted as a lock loss
          if (!lock_s) begin
            st  <= StWaitLock;
            cnt <= '0;
          end else if (cnt == FILT_END) begin
            st  <= StSdram;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StSdram: begin
          if (!lock_s) begin
            st  <= StWaitLock;
            cnt <= '0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
          end else if (cnt == SDRAM_END) begin
            st  <= StVideo;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StVideo: begin
          if (!lock_s) begin
            st  <= StWaitLock;
            cnt <= '0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
          end else if (soft_rst) begin
            cnt <= '0;  // game delay restarts after soft reset falls
          end else if (cnt == GAME_END) begin
            st  <= StRun;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StRun: begin
          if (!lock_s) begin
            st  <= StWaitLock;
            cnt <= '0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
          end else if (soft_rst) begin
            st  <= StVideo;
            cnt <= '0;
          end
        end
        default: begin
          st  <= StWaitLock;
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef JTFRAME_PLL_WDOG_EN
  localparam logic [CW-1:0] WDOG_END = CW'(WDOG_CYC - 1);
  localparam int unsigned   AW       = $clog2(AREST_LEN);

  logic [CW-1:0] wdog;
  logic [AW-1:0] arest_cnt;
  logic          wdog_run;
  logic          wdog_fire;

  always_comb begin
    wdog_run  = (st == StWaitLock) || (st == StFilter);
    wdog_fire = wdog_run && (wdog == WDOG_END);
  end

  // Watchdog: while lock is not accepted, periodically request a PLL reset pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog       <= '0;
      arest_cnt  <= '0;
      pll_areset <= 1'b0;
    end else begin
      if (!wdog_run || wdog_fire) wdog <= '0;
      else                        wdog <= wdog + CW'(1);
      if (wdog_fire) begin
        pll_areset <= 1'b1;
        arest_cnt  <= AW'(AREST_LEN - 1);
      end else if (arest_cnt != '0) begin
        arest_cnt <= arest_cnt - AW'(1);
      end else begin
        pll_areset <= 1'b0;
      end
    end
  end
`else
  assign pll_areset = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_rstseq.sv
// Self-checking bench for jtframe_rstseq: a default-parameter instance for
// timing checks and a short-delay instance for saturation and watchdog checks.
module tb_jtframe_rstseq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, lock_a, soft_a;
  logic       sdram_a, video_a, game_a, areset_a;
  logic [2:0] st_a;
  logic [7:0] loss_a;

  logic       rst_b, lock_b, soft_b;
  logic       sdram_b, video_b, game_b, areset_b;
  logic [2:0] st_b;
  logic [7:0] loss_b;

  jtframe_rstseq u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .pll_locked (lock_a),
    .soft_rst   (soft_a),
    .rst_sdram  (sdram_a),
    .rst_video  (video_a),
    .rst_game   (game_a),
    .pll_areset (areset_a),
    .seq_st     (st_a),
    .loss_cnt   (loss_a)
  );

  jtframe_rstseq #(
    .SYNC_STAGES (2),
    .LOCK_FILT   (2),
    .SDRAM_DLY   (3),
    .GAME_DLY    (2),
    .WDOG_CYC    (100)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .pll_locked (lock_b),
    .soft_rst   (soft_b),
    .rst_sdram  (sdram_b),
    .rst_video  (video_b),
    .rst_game   (game_b),
    .pll_areset (areset_b),
    .seq_st     (st_b),
    .loss_cnt   (loss_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int   edge_n;
    logic sdram;
    logic video;
    logic game;
    int   st;
  } vec_t;

  vec_t acq[7];

  // Edge 0 is the first edge sampling pll_locked=1
  task automatic acquire_a(input int exp_loss);
    int k;
    k = 0;
    lock_a = 1'b1;
    for (int e = 0; e <= 1299; e++) begin
      tick();
      if (k < 7 && acq[k].edge_n == e) begin
        chk($sformatf("acq_sdram@%0d", e), int'(sdram_a), int'(acq[k].sdram));
        chk($sformatf("acq_video@%0d", e), int'(video_a), int'(acq[k].video));
        chk($sformatf("acq_game@%0d", e),  int'(game_a),  int'(acq[k].game));
        chk($sformatf("acq_st@%0d", e),    int'(st_a),    acq[k].st);
        k++;
      end
    end
    chk("acq_loss", int'(loss_a), exp_loss);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int got, high, rises, first_rise, exp_loss;
    logic prev;

    acq[0] = '{edge_n: 17,   sdram: 1'b1, video: 1'b1, game: 1'b1, st: 1};
    acq[1] = '{edge_n: 18,   sdram: 1'b1, video: 1'b1, game: 1'b1, st: 2};
    acq[2] = '{edge_n: 19,   sdram: 1'b0, video: 1'b1, game: 1'b1, st: 2};
    acq[3] = '{edge_n: 1042, sdram: 1'b0, video: 1'b1, game: 1'b1, st: 3};
    acq[4] = '{edge_n: 1043, sdram: 1'b0, video: 1'b0, game: 1'b1, st: 3};
    acq[5] = '{edge_n: 1298, sdram: 1'b0, video: 1'b0, game: 1'b1, st: 4};
    acq[6] = '{edge_n: 1299, sdram: 1'b0, video: 1'b0, game: 1'b0, st: 4};

    rst_a = 1'b1; lock_a = 1'b0; soft_a = 1'b0;
    rst_b = 1'b1; lock_b = 1'b0; soft_b = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_sdram", int'(sdram_a), 1);
    chk("rst_video", int'(video_a), 1);
    chk("rst_game",  int'(game_a),  1);
    chk("rst_st",    int'(st_a),    0);
    chk("rst_loss",  int'(loss_a),  0);
    chk("rst_areset", int'(areset_a), 0);
    rst_a = 1'b0;
    repeat (5) tick();
    chk("nolock_st",   int'(st_a),    0);
    chk("nolock_game", int'(game_a),  1);

    acquire_a(0);

    // Soft reset held for 50 cycles while in RUN
    soft_a = 1'b1;
    tick();
    chk("soft_game_S", int'(game_a), 0);
    chk("soft_st_S",   int'(st_a),   3);
    tick();
    chk("soft_game_S1", int'(game_a), 1);
    repeat (48) tick();
    soft_a = 1'b0;
    chk("soft_sdram_hold", int'(sdram_a), 0);
    chk("soft_video_hold", int'(video_a), 0);
    chk("soft_game_hold",  int'(game_a),  1);
    repeat (256) tick();
    chk("soft_game_F255", int'(game_a), 1);
    tick();
    chk("soft_game_F256",  int'(game_a),  0);
    chk("soft_st_F256",    int'(st_a),    4);
    chk("soft_sdram_F256", int'(sdram_a), 0);
    chk("soft_video_F256", int'(video_a), 0);

    // Lock loss in RUN
    lock_a = 1'b0;
    tick();
    tick();
    chk("loss_game_L1", int'(game_a), 0);
    tick();
    chk("loss_game_L2", int'(game_a), 0);
    chk("loss_st_L2",   int'(st_a),   0);
    chk("loss_cnt_L2",  int'(loss_a), 1);
    tick();
    chk("loss_sdram_L3", int'(sdram_a), 1);
    chk("loss_video_L3", int'(video_a), 1);
    chk("loss_game_L3",  int'(game_a),  1);
    repeat (3) tick();
    acquire_a(1);

    // Synchronous reset mid-run
    rst_a = 1'b1; lock_a = 1'b0;
    tick();
    chk("mid_rst_sdram", int'(sdram_a), 1);
    chk("mid_rst_video", int'(video_a), 1);
    chk("mid_rst_game",  int'(game_a),  1);
    chk("mid_rst_st",    int'(st_a),    0);
    chk("mid_rst_loss",  int'(loss_a),  0);
    rst_a = 1'b0;
    repeat (3) tick();

    // Lock glitch during FILTER at filter count 10
    lock_a = 1'b1;
    repeat (11) tick();
    chk("glitch_st_pre", int'(st_a), 1);
    lock_a = 1'b0;
    repeat (3) tick();
    chk("glitch_st_wait", int'(st_a),   0);
    chk("glitch_loss",    int'(loss_a), 0);
    lock_a = 1'b1;
    repeat (19) tick();
    chk("glitch_sdram_32", int'(sdram_a), 1);
    chk("glitch_st_32",    int'(st_a),    2);
    tick();
    chk("glitch_sdram_33", int'(sdram_a), 0);
    chk("glitch_loss_end", int'(loss_a),  0);
    rst_a = 1'b1; lock_a = 1'b0;

    // Watchdog behaviour on the short instance with lock held low
    tick();
    rst_b = 1'b0;
    high = 0; rises = 0; first_rise = -1; prev = 1'b0;
    for (int e = 0; e < 350; e++) begin
      tick();
      if (areset_b) high++;
      if (areset_b && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = e;
      end
      prev = areset_b;
    end
`ifdef JTFRAME_PLL_WDOG_EN
    chk("wdog_high_cycles", high, 24);
    chk("wdog_pulses", rises, 3);
    chk("wdog_first_rise", first_rise, 99);
`else
    chk("wdog_off_high", high, 0);
`endif

    // Loss counter saturation over 300 lock losses from RUN
    for (int i = 0; i < 300; i++) begin
      lock_b = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
        tick();
        if (!game_b) got = 1;
      end
      chk($sformatf("sat_run_%0d", i), got, 1);
      lock_b = 1'b0;
      repeat (4) tick();
      exp_loss = (i + 1 > 255) ? 255 : i + 1;
      chk($sformatf("sat_loss_%0d", i), int'(loss_b), exp_loss);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtframe_rstseq.md
# jtframe_rstseq

PLL-lock-driven reset sequencer. It watches the game PLL `locked` flag and filters it. It then releases the SDRAM, video and game resets in a fixed staggered order, and re-runs the sequence whenever lock is lost. It runs on the board reference clock, not a PLL output, so it keeps working while the PLL is unlocked. Its outputs feed per-domain reset synchronizers in the PLL clock domains.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `pll_locked` (≥2).
- `LOCK_FILT`, 16: consecutive synchronized-high cycles required before lock is accepted (≥1).
- `SDRAM_DLY`, 1024: cycles from `rst_sdram` release to `rst_video` release (≥1).
- `GAME_DLY`, 256: cycles from `rst_video` release to `rst_game` release (≥1).
- `WDOG_CYC`, 65536: watchdog timeout in cycles; used only with the watchdog macro.
- `clk` in 1: board reference clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: asynchronous PLL lock flag.
- `soft_rst` in 1: user or OSD game reset request, level sensitive, synchronous to `clk`.
- `rst_sdram` out 1: SDRAM controller reset, active high.
- `rst_video` out 1: video timing reset, active high.
- `rst_game` out 1: game core reset, active high.
- `pll_areset` out 1: PLL reset pulse request (watchdog).
- `seq_st` out 3: current FSM state encoding, for debug.
- `loss_cnt` out 8: count of lock losses after acceptance, saturating at 255.

## Operation
- `lock_s` is `pll_locked` after `SYNC_STAGES` flops; the FSM uses only `lock_s`.
- The FSM has five states: WAIT_LOCK=0, FILTER=1, SDRAM=2, VIDEO=3, RUN=4. One shared counter `cnt` is cleared on every state change.
- **WAIT_LOCK**: all three resets high. When `lock_s`=1, go to FILTER.
- **FILTER**: all resets high.
  - `lock_s`=0: back to WAIT_LOCK.
  - `cnt`==LOCK_FILT-1: go to SDRAM.
- **SDRAM**: `rst_sdram`=0, others high. When `cnt`==SDRAM_DLY-1, go to VIDEO.
- **VIDEO**: `rst_sdram`=0, `rst_video`=0, `rst_game`=1. When `cnt`==GAME_DLY-1, go to RUN.
- **RUN**: all resets low.
- **Lock loss**: `lock_s`=0 in SDRAM, VIDEO or RUN → WAIT_LOCK.
  - All resets go high on the next edge.
  - `loss_cnt` increments (saturating).
  - Lock loss in FILTER does not increment `loss_cnt`.
- **Soft reset**: `soft_rst`=1 in VIDEO or RUN → state VIDEO with `cnt` held at 0 while `soft_rst` stays high. `rst_game` is therefore high while `soft_rst` is high, and for GAME_DLY cycles after it falls. `soft_rst` is ignored in WAIT_LOCK, FILTER and SDRAM, where the game is already held in reset.
- **Priority**: `rst` > lock loss > `soft_rst` > counter transitions.
- **Counter width**: `$clog2` of the largest of LOCK_FILT, SDRAM_DLY, GAME_DLY, WDOG_CYC. `cnt` never wraps; it stops at each state's terminal value.
- **Reset values**: `rst_sdram`=`rst_video`=`rst_game`=1, `pll_areset`=0, `loss_cnt`=0, `seq_st`=WAIT_LOCK, `cnt`=0, synchronizer flops=0.
- Asserting `rst` mid-sequence returns the block to the reset values on the next edge.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Lock acquisition: let edge 0 be the first `clk` edge that samples `pll_locked`=1. With `pll_locked` held high, `rst_sdram` falls at edge SYNC_STAGES+LOCK_FILT+1 (19 with defaults).
- `rst_video` falls SDRAM_DLY edges after `rst_sdram`. `rst_game` falls GAME_DLY edges after `rst_video`.
- Lock loss: all resets are high SYNC_STAGES+1 edges after the first edge that samples `pll_locked`=0.
- Soft reset: `rst_game` rises 1 edge after `soft_rst` is sampled high. It falls GAME_DLY edges after the first edge that samples `soft_rst` low.

## Configuration
- **`JTFRAME_PLL_WDOG_EN` defined**:
  - In WAIT_LOCK and FILTER, a watchdog counter runs. It is cleared on entry to SDRAM and on `rst`.
  - On reaching WDOG_CYC-1, `pll_areset` goes high for exactly 8 cycles and the watchdog restarts from 0.
  - Lock loss in a later state restarts the watchdog.
- **Not defined**: `pll_areset` is tied to 0 and the watchdog counter is not instantiated.

## Structure
- Package `jtframe_rstseq_pkg`:
  - `typedef enum logic [2:0]` for the FSM states, with the encodings above.
  - Constant `AREST_LEN`=8.
  - Width helper function for `cnt`.
- One sub-module, `jtframe_rstseq_sync`: a parameterized N-stage single-bit synchronizer with synchronous reset to 0.

## Test plan
- Reset, then `pll_locked` rises and stays high → `rst_sdram` falls at edge 19, `rst_video` at 1043, `rst_game` at 1299. `seq_st` ends at 4 and `loss_cnt`=0.
- During FILTER, pull `pll_locked` low for 3 cycles at filter count 10 → FSM returns to WAIT_LOCK. The full 16-cycle filter restarts, and `loss_cnt` stays 0.
- In RUN, drop `pll_locked` → all resets are high 3 edges later, `loss_cnt`=1. On re-lock, the full sequence replays.
- In RUN, hold `soft_rst` high for 50 cycles → `rst_game` is high from the next edge until 256 edges after release. `rst_sdram` and `rst_video` stay 0.
- Drop `pll_locked` 300 times with the block reaching RUN each time → `loss_cnt` saturates at 255 and never wraps.
- With `JTFRAME_PLL_WDOG_EN` and `WDOG_CYC`=100, hold `pll_locked`=0 → `pll_areset` pulses 8 cycles wide, once every 100 cycles. Without the macro, `pll_areset` stays 0.
